// File: rtl/gf_sbox_pkg.sv
// Shared state encoding, field-mapping matrices and scalar constants for the composite-field S-box.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package gf_sbox_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  // Row i (bits 8i+7:8i) selects the input bits XORed into output bit i.
  localparam logic [63:0] ISO_MAP     = 64'hA0DE_ACAE_C69E_5243;
  localparam logic [63:0] ISO_INV_MAP = 64'hE244_6276_3E9E_3075;
  localparam logic [63:0] AFF_MAP     = 64'hF87C_3E1F_8FC7_E3F1;
  localparam logic [7:0]  AFF_C       = 8'h63;
  localparam logic [63:0] INV_AFF_MAP = 64'h5229_944A_2592_49A4;
  localparam logic [7:0]  INV_AFF_C   = 8'h05;

  // GF(2^2) reduction scalar (phi) and GF(2^4) extension scalar (lambda).
  localparam logic [1:0]  GF4_PHI     = 2'b10;
  localparam logic [3:0]  GF8_LAMBDA  = 4'b1100;

  function automatic logic [7:0] mat8(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = ^(m[8*i +: 8] & x);
    end
    return r;
  endfunction

  function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

endpackage

// File: rtl/gf4_inv.sv
// GF((2^2)^2) multiplicative inverse; 0 maps to 0.
// Latency: combinational.
// Backpressure: n/a.
module gf4_inv (
  input  logic [3:0] q,
  output logic [3:0] y
);
  logic q3, q2, q1, q0;

  assign {q3, q2, q1, q0} = q;

  assign y[3] = q3 ^ (q3 & q2 & q1) ^ (q3 & q0) ^ q2;
  assign y[2] = (q3 & q2 & q1) ^ (q3 & q2 & q0) ^ (q3 & q0) ^ q2 ^ (q2 & q1);
  assign y[1] = q3 ^ (q3 & q2 & q1) ^ (q3 & q1 & q0) ^ q2 ^ (q2 & q0) ^ q1;
  assign y[0] = (q3 & q2 & q1) ^ (q3 & q2 & q0) ^ (q3 & q1) ^ (q3 & q1 & q0) ^ (q3 & q0)
              ^ q2 ^ (q2 & q1) ^ (q2 & q1 & q0) ^ q1 ^ q0;

endmodule

// File: rtl/gf4_mul.sv
// GF((2^2)^2) multiplier cell.
// Latency: combinational.
// Backpressure: n/a.
module gf4_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);
  import gf_sbox_pkg::*;

  logic [1:0] hh, hl, lh, ll;

  assign hh = gf2_mul(a[3:2], b[3:2]);
  assign hl = gf2_mul(a[3:2], b[1:0]);
  assign lh = gf2_mul(a[1:0], b[3:2]);
  assign ll = gf2_mul(a[1:0], b[1:0]);
  assign p  = {hh ^ hl ^ lh, gf2_mul(hh, GF4_PHI) ^ ll};

endmodule

// File: rtl/gf4_sq_scl.sv
// GF((2^2)^2) squarer followed by multiplication with lambda.
// Latency: combinational.
// Backpressure: n/a.
module gf4_sq_scl (
  input  logic [3:0] a,
  output logic [3:0] y
);
  import gf_sbox_pkg::*;

  logic [3:0] sq;

  assign sq = {a[3], a[3] ^ a[2], a[2] ^ a[1], a[3] ^ a[1] ^ a[0]};

  gf4_mul u_scl (
    .a (sq),
    .b (GF8_LAMBDA),
    .p (y)
  );

endmodule

// File: rtl/gf_sbox_byte_pipe.sv
// Composite-field byte S-box: stage-1 register inside, stage-2 logic feeds the caller's register.
// Latency: 1 clock to byte_out (caller registers stage 2). GF_SBOX_INV_EN enables the inverse path.
// Backpressure: none; free-running, the caller only samples valid lanes.
module gf_sbox_byte_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);
  import gf_sbox_pkg::*;

  logic [7:0] pre_map;
  logic [7:0] iso;
  logic [3:0] hi_d, hi_q, sum_d, sum_q, prod_d, prod_q, sqs_d, sqs_q;
  logic [3:0] prod_w, sqs_w;
  logic [3:0] delta, delta_inv, out_hi, out_lo;
  logic [7:0] gf_inv_byte;
  logic       fwd_out;

`ifdef GF_SBOX_INV_EN
  logic inv_d, inv_q;

  assign pre_map = inv ? (mat8(INV_AFF_MAP, byte_in) ^ INV_AFF_C) : byte_in;
  assign inv_d   = inv;
  assign fwd_out = ~inv_q;
`else
  logic unused_inv;

  assign unused_inv = inv;
  assign pre_map    = byte_in;
  assign fwd_out    = 1'b1;
`endif

  assign iso = mat8(ISO_MAP, pre_map);

  gf4_mul    u_s1_mul (.a(iso[7:4] ^ iso[3:0]), .b(iso[3:0]), .p(prod_w));
  gf4_sq_scl u_s1_sqs (.a(iso[7:4]), .y(sqs_w));

  always_comb begin
    hi_d   = iso[7:4];
    sum_d  = iso[7:4] ^ iso[3:0];
    prod_d = prod_w;
    sqs_d  = sqs_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      sum_q  <= '0;
      prod_q <= '0;
      sqs_q  <= '0;
`ifdef GF_SBOX_INV_EN
      inv_q  <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      sum_q  <= sum_d;
      prod_q <= prod_d;
      sqs_q  <= sqs_d;
`ifdef GF_SBOX_INV_EN
      inv_q  <= inv_d;
`endif
    end
  end

  // Stage 2: (hi*d^-1, (hi^lo)*d^-1) is the inverse in GF((2^4)^2).
  assign delta = sqs_q ^ prod_q;

  gf4_inv u_s2_inv (.q(delta), .y(delta_inv));
  gf4_mul u_s2_hi  (.a(hi_q),  .b(delta_inv), .p(out_hi));
  gf4_mul u_s2_lo  (.a(sum_q), .b(delta_inv), .p(out_lo));

  assign gf_inv_byte = mat8(ISO_INV_MAP, {out_hi, out_lo});
  assign byte_out    = fwd_out ? (mat8(AFF_MAP, gf_inv_byte) ^ AFF_C) : gf_inv_byte;

endmodule

// File: rtl/gf_sbox_word_seq.sv
// Word-level SubBytes/InvSubBytes sequencer: streams 4 bytes through gf_sbox_byte_pipe (GF_SBOX_INV_EN enables inverse).
// Latency: out_valid 5 clocks after acceptance; one word per 7 clocks minimum.
// Backpressure: out_data/out_valid held while out_ready is low; in_ready only in IDLE.
module gf_sbox_word_seq #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data
);
  import gf_sbox_pkg::*;

  localparam int               CNT_W = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_BYTES - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       s1_lane_q, s1_lane_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [8*NUM_BYTES-1:0] word_q, word_d;
  logic [8*NUM_BYTES-1:0] out_data_q, out_data_d;
  logic                   inv_q, inv_d;
  logic [7:0]             byte_feed, byte_sub;

  gf_sbox_byte_pipe u_byte_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_in  (byte_feed),
    .inv      (inv_q),
    .byte_out (byte_sub)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign byte_feed = word_q[8*cnt_q +: 8];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    inv_d      = inv_q;
    s1_vld_d   = 1'b0;
    s1_lane_d  = cnt_q;
    out_data_d = out_data_q;

    if (s1_vld_q) begin
      out_data_d[8*s1_lane_q +: 8] = byte_sub;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
`ifdef GF_SBOX_INV_EN
          inv_d   = in_inv;
`else
          inv_d   = 1'b0;
`endif
          cnt_d   = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        s1_vld_d = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifndef GF_SBOX_INV_EN
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s1_lane_q  <= '0;
      s1_vld_q   <= 1'b0;
      word_q     <= '0;
      out_data_q <= '0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_lane_q  <= s1_lane_d;
      s1_vld_q   <= s1_vld_d;
      word_q     <= word_d;
      out_data_q <= out_data_d;
      inv_q      <= inv_d;
    end
  end

endmodule

// File: tb/tb_gf_sbox_word_seq.sv
// Directed bench for gf_sbox_word_seq with hand-computed AES S-box words.
// Inverse-path vectors are compiled only when GF_SBOX_INV_EN is defined.
module tb_gf_sbox_word_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  gf_sbox_word_seq #(.NUM_BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one word from IDLE, scrambles the pins afterwards, measures latency and result.
  task automatic run_word(input logic [31:0] d, input logic inv, input logic [31:0] exp,
                          input string tag);
    int lat;
    in_data  = d;
    in_inv   = inv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_inv   = ~inv;
    check_eq({tag, "_busy"}, {31'b0, in_ready}, 32'h0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd5);
    check_eq({tag, "_dat"}, out_data, exp);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_idle"}, {30'b0, out_valid, in_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        acc;
    int          n_acc;
    int          n_out;
    logic [31:0] out_w [2];
    int          out_c [2];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_vld_rdy", {30'b0, out_valid, in_ready}, 32'h1);
    check_eq("rst_dat", out_data, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_word(32'h0001_53FF, 1'b0, 32'h637C_ED16, "fwd");
    consume("fwd");

`ifdef GF_SBOX_INV_EN
    run_word(32'h637C_ED16, 1'b1, 32'h0001_53FF, "inv");
    consume("inv");
`else
    run_word(32'h0000_0000, 1'b1, 32'h6363_6363, "noinv");
    consume("noinv");
`endif

    // Backpressure with a stray in_valid pulse that must be ignored.
    run_word(32'h0000_0053, 1'b0, 32'h6363_63ED, "bp");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check_eq($sformatf("bp_hold%0d", i), out_data, 32'h6363_63ED);
      check_eq($sformatf("bp_flags%0d", i), {30'b0, out_valid, in_ready}, 32'h2);
    end
    in_valid = 1'b0;
    consume("bp");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("bp_quiet%0d", i), {30'b0, out_valid, in_ready}, 32'h1);
    end

    // Back-to-back with in_valid and out_ready held high.
    in_data   = 32'h0000_0000;
    in_inv    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_acc     = 0;
    n_out     = 0;
    for (int i = 0; i < 40 && n_out < 2; i++) begin
      acc = in_valid & in_ready;
      tick();
      if (acc) begin
        n_acc++;
        in_data = 32'hFFFF_FFFF;
      end
      if (out_valid) begin
        out_w[n_out] = out_data;
        out_c[n_out] = cyc;
        n_out++;
        if (n_out == 2) in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("b2b_nout", 32'(n_out), 32'd2);
    check_eq("b2b_nacc", 32'(n_acc), 32'd2);
    if (n_out == 2) begin
      check_eq("b2b_w0", out_w[0], 32'h6363_6363);
      check_eq("b2b_w1", out_w[1], 32'h1616_1616);
      check_eq("b2b_gap", 32'(out_c[1] - out_c[0]), 32'd7);
    end
    consume("b2b");

    // Reset after lane 1 has entered stage 1.
    in_data  = 32'h1234_5678;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_flags", {30'b0, out_valid, in_ready}, 32'h1);
    check_eq("rstmid_dat", out_data, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_word(32'h0101_0101, 1'b0, 32'h7C7C_7C7C, "post_rst");
    consume("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
